// File: rtl/cache_request_arbiter.sv
// cache_request_arbiter: serialises single-word read/write requests from
// NUM_PORTS requesters onto one memory port. It supports fixed-priority or
// round-robin arbitration and an optional watchdog that turns a missing
// memory response into an error completion.
module cache_request_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int ID_W          = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_write_data,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic                            rsp_error,
  output logic [DATA_WIDTH-1:0]           rsp_read_data,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy,
  output logic                            memory_read_request,
  output logic                            memory_write_request,
  output logic [ADDR_WIDTH-1:0]           memory_addr,
  output logic [DATA_WIDTH-1:0]           memory_write_data,
  input  logic                            memory_response,
  input  logic [DATA_WIDTH-1:0]           memory_read_data
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int             TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [0:0]            r_state;
  logic [NUM_PORTS-1:0]  r_rsp_valid;
  logic                  r_rsp_error;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       r_last_grant;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [TO_W-1:0]       r_to_cnt;

  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_elig;
  logic [NUM_PORTS-1:0]  w_grant_onehot;
  logic [ID_W-1:0]       w_sel;
  logic                  w_any;

  // Unpack the flat per-port buses into indexable arrays.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign w_addr_arr[gi]  = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata_arr[gi] = req_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // A port whose completion is pulsing this cycle is masked so it can drop its request.
  assign w_elig         = (req_read | req_write) & ~r_rsp_valid;
  assign w_grant_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grant_id;

  // Choose the winning port: highest index, or first after last_grant in round-robin.
  always_comb begin
    int idx;
    idx   = 0;
    w_sel = '0;
    w_any = 1'b0;
    if (ARB_MODE == 0) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_elig[p]) begin
          w_sel = ID_W'(p);
          w_any = 1'b1;
        end
      end
    end else begin
      // Walk the search order backwards so the last hit is the nearest one.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = int'(r_last_grant) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (w_elig[idx]) begin
          w_sel = ID_W'(idx);
          w_any = 1'b1;
        end
      end
    end
  end

  // Transaction FSM: grant in IDLE, hold the memory request in BUSY until response or timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rsp_valid  <= '0;
      r_rsp_error  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(NUM_PORTS - 1);
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state      <= S_BUSY;
            r_grant_id   <= w_sel;
            r_last_grant <= w_sel;
            r_mem_addr   <= w_addr_arr[w_sel];
            r_mem_wdata  <= w_wdata_arr[w_sel];
            // A port asserting both read and write is treated as a write.
            r_mem_wr     <= req_write[w_sel];
            r_mem_rd     <= ~req_write[w_sel];
            r_to_cnt     <= '0;
          end
        end
        default: begin
          if (memory_response) begin
            r_state     <= S_IDLE;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_rsp_valid <= w_grant_onehot;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= memory_read_data;
          end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
            r_state     <= S_IDLE;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_rsp_valid <= w_grant_onehot;
            r_rsp_error <= 1'b1;
            r_rsp_rdata <= '0;
          end else if (TO_EN) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign rsp_valid            = r_rsp_valid;
  assign rsp_error            = r_rsp_error;
  assign rsp_read_data        = r_rsp_rdata;
  assign grant_id             = r_grant_id;
  assign busy                 = (r_state == S_BUSY);
  assign memory_read_request  = r_mem_rd;
  assign memory_write_request = r_mem_wr;
  assign memory_addr          = r_mem_addr;
  assign memory_write_data    = r_mem_wdata;

endmodule

// File: tb/tb_cache_request_arbiter.sv
// Directed bench: a 2-port fixed-priority instance and a 4-port round-robin
// instance with an 8-cycle watchdog, driven and checked step by step.
module tb_cache_request_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 2 ports, fixed priority, no timeout
  logic [63:0] a_addr, a_wdata;
  logic [1:0]  a_rd, a_wr, a_vld;
  logic        a_err, a_busy, a_mrd, a_mwr, a_mresp;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic [0:0]  a_gid;

  // Instance B: 4 ports, round-robin, timeout 8
  logic [127:0] b_addr, b_wdata;
  logic [3:0]   b_rd, b_wr, b_vld;
  logic         b_err, b_busy, b_mrd, b_mwr, b_mresp;
  logic [31:0]  b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic [1:0]   b_gid;

  cache_request_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                          .ARB_MODE(0), .TIMEOUT_CYCLES(0)) dut_fp (
    .clk(clk), .reset(reset),
    .req_address(a_addr), .req_write_data(a_wdata),
    .req_read(a_rd), .req_write(a_wr),
    .rsp_valid(a_vld), .rsp_error(a_err), .rsp_read_data(a_rdata),
    .grant_id(a_gid), .busy(a_busy),
    .memory_read_request(a_mrd), .memory_write_request(a_mwr),
    .memory_addr(a_maddr), .memory_write_data(a_mwdata),
    .memory_response(a_mresp), .memory_read_data(a_mrdata)
  );

  cache_request_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                          .ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .reset(reset),
    .req_address(b_addr), .req_write_data(b_wdata),
    .req_read(b_rd), .req_write(b_wr),
    .rsp_valid(b_vld), .rsp_error(b_err), .rsp_read_data(b_rdata),
    .grant_id(b_gid), .busy(b_busy),
    .memory_read_request(b_mrd), .memory_write_request(b_mwr),
    .memory_addr(b_maddr), .memory_write_data(b_mwdata),
    .memory_response(b_mresp), .memory_read_data(b_mrdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          exp_seq [5];
    logic [3:0]  exp_vld;
    exp_seq = '{0, 1, 2, 3, 0};

    reset = 1'b0;
    a_addr = '0; a_wdata = '0; a_rd = '0; a_wr = '0; a_mresp = 1'b0; a_mrdata = '0;
    b_addr = '0; b_wdata = '0; b_rd = '0; b_wr = '0; b_mresp = 1'b0; b_mrdata = '0;
    #1;
    $display("step: reset values");
    check("rst_a_vld",  a_vld, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_req",  {a_mrd, a_mwr}, 0);
    check("rst_b_gid",  b_gid, 0);
    check("rst_b_out",  {b_err, b_rdata, b_maddr}, 0);
    tick();
    tick();
    reset = 1'b1;

    // Fixed priority: port0 read and port1 write together -> port1 first
    $display("step: fixed priority collision");
    a_addr  = {32'h0000_0200, 32'h0000_0100};
    a_wdata = {32'hDEAD_BEEF, 32'h0000_0000};
    a_rd = 2'b01; a_wr = 2'b10;
    tick();
    check("fp1_gid",   a_gid, 1);
    check("fp1_busy",  a_busy, 1);
    check("fp1_type",  {a_mwr, a_mrd}, 2'b10);
    check("fp1_addr",  a_maddr, 32'h200);
    check("fp1_wdata", a_mwdata, 32'hDEADBEEF);
    a_mresp = 1'b1; a_mrdata = 32'h1111_1111;
    tick();
    a_mresp = 1'b0;
    check("fp1_vld",   a_vld, 2'b10);
    check("fp1_err",   a_err, 0);
    check("fp1_idle",  {a_busy, a_mwr, a_mrd}, 0);
    a_wr = 2'b00;
    tick();
    $display("step: fixed priority second port");
    check("fp2_vld",   a_vld, 0);
    check("fp2_gid",   a_gid, 0);
    check("fp2_type",  {a_mwr, a_mrd}, 2'b01);
    check("fp2_addr",  a_maddr, 32'h100);
    a_mresp = 1'b1; a_mrdata = 32'h1234_5678;
    tick();
    a_mresp = 1'b0;
    check("fp2_vld",   a_vld, 2'b01);
    check("fp2_rdata", a_rdata, 32'h12345678);
    a_rd = 2'b00;
    tick();
    check("fp2_clr",   {a_vld, a_busy}, 0);

    // Read+write on one port -> write only; response in IDLE ignored
    $display("step: read and write on one port");
    a_addr[31:0] = 32'h0000_0300; a_wdata[31:0] = 32'h55AA_55AA;
    a_rd = 2'b01; a_wr = 2'b01;
    tick();
    check("rw_type",  {a_mwr, a_mrd}, 2'b10);
    check("rw_addr",  a_maddr, 32'h300);
    check("rw_wdata", a_mwdata, 32'h55AA55AA);
    a_mresp = 1'b1; a_mrdata = 32'h0000_0077;
    tick();
    check("rw_vld",   a_vld, 2'b01);
    check("rw_rdata", a_rdata, 32'h77);
    a_rd = 2'b00; a_wr = 2'b00;
    $display("step: stray memory response in idle");
    tick();
    check("idle_rsp1", {a_vld, a_busy}, 0);
    tick();
    a_mresp = 1'b0;
    check("idle_rsp2", {a_vld, a_busy}, 0);

    // Round-robin: all four ports requesting, latency 2
    b_addr = {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
    b_rd = 4'hF;
    for (int i = 0; i < 5; i++) begin
      $display("step: round-robin transaction %0d, expecting port %0d", i, exp_seq[i]);
      exp_vld = 4'b0001 << exp_seq[i];
      tick();
      check("rr_gid",   b_gid, 64'(exp_seq[i]));
      check("rr_vld0",  b_vld, 0);
      check("rr_mrd",   {b_busy, b_mrd, b_mwr}, 3'b110);
      check("rr_addr",  b_maddr, 64'(32'h1000 + 32'(exp_seq[i]) * 4));
      tick();
      check("rr_hold",  {b_mrd, b_vld}, 5'b10000);
      b_mresp = 1'b1; b_mrdata = 32'hA0 + 32'(i);
      tick();
      b_mresp = 1'b0;
      check("rr_vld",   b_vld, 64'(exp_vld));
      check("rr_err",   b_err, 0);
      check("rr_rdata", b_rdata, 64'(32'hA0 + 32'(i)));
      if (i == 4) b_rd = 4'h0;
    end

    // Latency-3 read returning 0xCAFEF00D, request stable throughout
    $display("step: latency-3 read");
    b_addr[64 +: 32] = 32'h0000_2000;
    b_rd = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("l3_gid",  b_gid, 2);
      check("l3_req",  {b_busy, b_mrd, b_mwr}, 3'b110);
      check("l3_addr", b_maddr, 32'h2000);
    end
    b_mresp = 1'b1; b_mrdata = 32'hCAFE_F00D;
    tick();
    b_mresp = 1'b0;
    check("l3_vld",   b_vld, 4'b0100);
    check("l3_err",   b_err, 0);
    check("l3_rdata", b_rdata, 32'hCAFEF00D);
    check("l3_idle",  {b_busy, b_mrd}, 0);
    b_rd = 4'b0000;
    tick();

    // Timeout: port 3 never answered, port 1 waiting behind it
    $display("step: watchdog timeout");
    b_addr[96 +: 32] = 32'h0000_3000;
    b_rd = 4'b1010;
    tick();
    check("to_gid",  b_gid, 3);
    check("to_busy", b_busy, 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("to_wait", {b_vld, b_busy, b_mrd}, 6'b000011);
    end
    tick();
    check("to_vld",   b_vld, 4'b1000);
    check("to_err",   b_err, 1);
    check("to_rdata", b_rdata, 0);
    check("to_idle",  {b_busy, b_mrd}, 0);
    b_rd = 4'b0010;
    tick();
    check("to_next_gid",  b_gid, 1);
    check("to_next_addr", b_maddr, 32'h1004);
    check("to_next_busy", {b_busy, b_vld}, 5'b10000);

    // Reset while busy: outputs clear at once, no completion, port 0 first after
    $display("step: reset while busy");
    tick();
    reset = 1'b0;
    #1;
    check("ar_b_out", {b_busy, b_mrd, b_mwr, b_vld, b_gid}, 0);
    check("ar_b_mem", b_maddr, 0);
    b_rd = 4'b0111;
    tick();
    tick();
    check("ar_noresp", b_vld, 0);
    reset = 1'b1;
    tick();
    check("ar_gid",  b_gid, 0);
    check("ar_busy", b_busy, 1);
    check("ar_addr", b_maddr, 32'h1000);
    check("ar_vld",  b_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
